// File: rtl/instr_encoder_if.sv
// Bus between instr_encoder and its environment: the field-tuple handshake from the
// loader and the instruction-memory write port. slave = encoder side, master = loader/memory side.
interface instr_encoder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_fmt;
    logic [3:0]        in_op;
    logic [3:0]        in_rd;
    logic [3:0]        in_rs;
    logic [3:0]        in_func;
    logic [3:0]        in_rt;
    logic [15:0]       in_imm;
    logic [19:0]       in_offs;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;

    modport slave (
        input  in_valid, in_fmt, in_op, in_rd, in_rs, in_func, in_rt, in_imm, in_offs,
        output in_ready,
        output mem_we, mem_addr, mem_wdata,
        input  mem_ack
    );

    modport master (
        output in_valid, in_fmt, in_op, in_rd, in_rs, in_func, in_rt, in_imm, in_offs,
        input  in_ready,
        input  mem_we, mem_addr, mem_wdata,
        output mem_ack
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs R/I/J instruction fields into 32-bit words and streams them to instruction memory
// through a small FIFO at auto-incrementing addresses. Optional trace output: ENC_TRACE_EN.
module instr_encoder #(
    parameter int unsigned       FIFO_DEPTH = 4,
    parameter int unsigned       ADDR_W     = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
    input  logic              clk,
    input  logic              rst_async,
    instr_encoder_if.slave    bus,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    output logic              busy,
    output logic              wrapped,
    output logic              err_fmt,
    input  logic              err_clr
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;

    localparam logic [1:0] FMT_R   = 2'd0;
    localparam logic [1:0] FMT_I   = 2'd1;
    localparam logic [1:0] FMT_J   = 2'd2;
    localparam logic [1:0] FMT_ILL = 2'd3;

    generate
        if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("instr_encoder: FIFO_DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wrapped_q, wrapped_d;
    logic              err_q, err_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;

    logic [WORD_W-1:0] packed_c;
    logic              accept_c;
    logic              illegal_c;
    logic              push_c;
    logic              pop_c;

    // Field packing; bits not owned by the format stay zero.
    always_comb begin
        packed_c = '0;
        case (bus.in_fmt)
            FMT_R:   packed_c = {bus.in_op, bus.in_rd, bus.in_rs, bus.in_func, 12'h000, bus.in_rt};
            FMT_I:   packed_c = {bus.in_op, bus.in_rd, bus.in_rs, bus.in_func, bus.in_imm};
            FMT_J:   packed_c = {bus.in_op, bus.in_rd, bus.in_rs, bus.in_offs};
            default: packed_c = '0;
        endcase
    end

    assign accept_c  = bus.in_valid && in_ready_q;
    assign illegal_c = accept_c && (bus.in_fmt == FMT_ILL);
    assign push_c    = accept_c && (bus.in_fmt != FMT_ILL);
    // The holding register refills whenever it is empty or its word is being acked.
    assign pop_c     = (count_q != '0) && (!mem_we_q || bus.mem_ack);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        addr_d      = addr_q;
        wrapped_d   = 1'b0;
        err_d       = err_q;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

        if (pop_c) begin
            mem_we_d    = 1'b1;
            mem_wdata_d = fifo_mem[rd_ptr_q];
            mem_addr_d  = addr_q;
            addr_d      = addr_q + ADDR_W'(1);
            wrapped_d   = (addr_q == '1);
        end else if (bus.mem_ack) begin
            mem_we_d = 1'b0;
        end

        // A loaded address replaces the increment; the word taken this cycle keeps the old one.
        if (load_en) begin
            addr_d    = load_addr;
            wrapped_d = 1'b0;
        end

        if (illegal_c) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end

        in_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
        busy_d     = (count_d != '0) || mem_we_d;
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= packed_c;
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            addr_q      <= BASE_ADDR;
            wrapped_q   <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            addr_q      <= addr_d;
            wrapped_q   <= wrapped_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign wrapped       = wrapped_q;
    assign err_fmt       = err_q;

`ifdef ENC_TRACE_EN
    always @(posedge clk) begin
        if (!rst_async && mem_we_q && bus.mem_ack) begin
            $display("ENCODER addr=%h data=%h op=%h rd=%h rs=%h",
                     mem_addr_q, mem_wdata_q, mem_wdata_q[31:28], mem_wdata_q[27:24],
                     mem_wdata_q[23:20]);
        end
        if (!rst_async && illegal_c) begin
            $display("ENCODER warning: illegal format tuple dropped op=%h rd=%h", bus.in_op, bus.in_rd);
        end
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: packing table plus stall, wrap, illegal-format and reset sequences.
module tb_instr_encoder;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DEPTH  = 4;
    localparam logic [ADDR_W-1:0] BASE = 10'h000;

    typedef struct {
        logic [1:0]  fmt;
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  func;
        logic [3:0]  rt;
        logic [15:0] imm;
        logic [19:0] offs;
        logic [31:0] exp;
    } vec_t;

    logic              clk;
    logic              rst_async;
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic              busy;
    logic              wrapped;
    logic              err_fmt;
    logic              err_clr;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(
        .FIFO_DEPTH(DEPTH),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE)
    ) dut (
        .clk      (clk),
        .rst_async(rst_async),
        .bus      (bus),
        .load_en  (load_en),
        .load_addr(load_addr),
        .busy     (busy),
        .wrapped  (wrapped),
        .err_fmt  (err_fmt),
        .err_clr  (err_clr)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0]       wq [$];
    logic [ADDR_W-1:0] aq [$];
    int                cq [$];
    int                cyc = 0;
    int                wrap_cnt = 0;
    bit                mon_en = 1'b0;

    vec_t vecs [8];
    vec_t ill;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Records every write that memory will take at the coming edge, and wrapped pulses.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_en && !rst_async) begin
                if (bus.mem_we && bus.mem_ack) begin
                    wq.push_back(bus.mem_wdata);
                    aq.push_back(bus.mem_addr);
                    cq.push_back(cyc);
                end
                if (wrapped) wrap_cnt++;
            end
        end
    end

    function automatic vec_t mk(input logic [1:0] fmt, input logic [3:0] op, input logic [3:0] rd,
                                input logic [3:0] rs, input logic [3:0] func, input logic [3:0] rt,
                                input logic [15:0] imm, input logic [19:0] offs, input logic [31:0] exp);
        vec_t v;
        v.fmt = fmt; v.op = op; v.rd = rd; v.rs = rs; v.func = func;
        v.rt = rt; v.imm = imm; v.offs = offs; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tuple(input vec_t v);
        bus.in_fmt  = v.fmt;
        bus.in_op   = v.op;
        bus.in_rd   = v.rd;
        bus.in_rs   = v.rs;
        bus.in_func = v.func;
        bus.in_rt   = v.rt;
        bus.in_imm  = v.imm;
        bus.in_offs = v.offs;
    endtask

    // Presents one tuple until accepted; returns just after the accepting edge.
    task automatic send(input vec_t v);
        bit ok;
        bit acc;
        ok = 1'b0;
        set_tuple(v);
        bus.in_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            acc = bus.in_ready;
            tick();
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout in_ready never rose, required 1");
        end
    endtask

    task automatic do_reset();
        rst_async    = 1'b1;
        bus.in_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        load_en      = 1'b0;
        err_clr      = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_async = 1'b0;
        wq.delete();
        aq.delete();
        cq.delete();
        wrap_cnt = 0;
        tick();
    endtask

    function automatic vec_t stall_vec(input int i);
        logic [3:0] i4;
        i4 = 4'(i);
        return mk(2'd0, i4, 4'hC, 4'h0, 4'h0, i4, 16'h0, 20'h0, {i4, 4'hC, 20'h00000, i4});
    endfunction

    initial begin
        logic [ADDR_W-1:0] exp_addr;
        bit acc;

        rst_async    = 1'b1;
        load_en      = 1'b0;
        load_addr    = '0;
        err_clr      = 1'b0;
        bus.in_valid = 1'b0;
        bus.mem_ack  = 1'b0;
        set_tuple(mk(2'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0, 20'h0, 32'h0));

        vecs[0] = mk(2'd0, 4'h3, 4'h1, 4'h2, 4'h4, 4'h5, 16'h0000, 20'h00000, 32'h31240005);
        vecs[1] = mk(2'd1, 4'h1, 4'h2, 4'h3, 4'h0, 4'h0, 16'hBEEF, 20'h00000, 32'h1230BEEF);
        vecs[2] = mk(2'd2, 4'hA, 4'h7, 4'h0, 4'h0, 4'h0, 16'h0000, 20'hFFFFF, 32'hA70FFFFF);
        vecs[3] = mk(2'd0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 16'hFFFF, 20'hFFFFF, 32'hFFFF000F);
        vecs[4] = mk(2'd1, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 16'hFFFF, 20'hFFFFF, 32'hFFFFFFFF);
        vecs[5] = mk(2'd2, 4'h0, 4'h0, 4'h5, 4'hF, 4'hF, 16'hFFFF, 20'h12345, 32'h00512345);
        vecs[6] = mk(2'd0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 16'hFFFF, 20'hFFFFF, 32'h23450006);
        vecs[7] = mk(2'd1, 4'h0, 4'h0, 4'h0, 4'h9, 4'hF, 16'h0001, 20'hFFFFF, 32'h00090001);
        ill     = mk(2'd3, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 16'hFFFF, 20'hFFFFF, 32'h0);

        // Reset values while reset is held
        repeat (2) @(negedge clk);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wrapped", 32'(wrapped), 32'd0);
        chk("rst_err_fmt", 32'(err_fmt), 32'd0);
        #2 rst_async = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        tick();

        // Packing table, one word at a time through an idle pipeline
        bus.mem_ack = 1'b1;
        exp_addr = BASE;
        for (int i = 0; i < 8; i++) begin
            send(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d_latency_we", i), 32'(bus.mem_we), 32'd0);
            chk($sformatf("vec%0d_busy_queued", i), 32'(busy), 32'd1);
            @(negedge clk);
            chk($sformatf("vec%0d_we", i), 32'(bus.mem_we), 32'd1);
            chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, vecs[i].exp);
            chk($sformatf("vec%0d_addr", i), 32'(bus.mem_addr), 32'(exp_addr));
            @(negedge clk);
            chk($sformatf("vec%0d_we_after_ack", i), 32'(bus.mem_we), 32'd0);
            chk($sformatf("vec%0d_busy_after_ack", i), 32'(busy), 32'd0);
            exp_addr = exp_addr + ADDR_W'(1);
            tick();
        end

        // Back-to-back I then J with mem_ack held high
        do_reset();
        mon_en = 1'b1;
        bus.mem_ack = 1'b1;
        set_tuple(vecs[1]);
        bus.in_valid = 1'b1;
        @(negedge clk);
        chk("b2b_ready0", 32'(bus.in_ready), 32'd1);
        tick();
        set_tuple(vecs[2]);
        @(negedge clk);
        chk("b2b_ready1", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        repeat (5) tick();
        chk("b2b_count", 32'(wq.size()), 32'd2);
        if (wq.size() >= 2) begin
            chk("b2b_data0", wq[0], 32'h1230BEEF);
            chk("b2b_addr0", 32'(aq[0]), 32'd0);
            chk("b2b_data1", wq[1], 32'hA70FFFFF);
            chk("b2b_addr1", 32'(aq[1]), 32'd1);
            chk("b2b_consecutive", 32'(cq[1] - cq[0]), 32'd1);
        end

        // Memory stall: five accepts fill the holding register and FIFO
        do_reset();
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_tuple(stall_vec(i));
            bus.in_valid = 1'b1;
            @(negedge clk);
            chk($sformatf("stall_ready%0d", i), 32'(bus.in_ready), 32'd1);
            tick();
        end
        set_tuple(stall_vec(5));
        @(negedge clk);
        chk("stall_full_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_we", 32'(bus.mem_we), 32'd1);
        chk("stall_data", bus.mem_wdata, stall_vec(0).exp);
        chk("stall_addr", 32'(bus.mem_addr), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("stall_hold_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_hold_we", 32'(bus.mem_we), 32'd1);
        chk("stall_hold_data", bus.mem_wdata, stall_vec(0).exp);
        chk("stall_hold_addr", 32'(bus.mem_addr), 32'd0);
        chk("stall_busy", 32'(busy), 32'd1);
        tick();
        bus.mem_ack = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) bus.in_valid = 1'b0;
        end
        chk("stall_sixth_taken", 32'(bus.in_valid), 32'd0);
        chk("stall_count", 32'(wq.size()), 32'd6);
        for (int j = 0; j < 6; j++) begin
            if (j < wq.size()) begin
                chk($sformatf("stall_data%0d", j), wq[j], stall_vec(j).exp);
                chk($sformatf("stall_addr%0d", j), 32'(aq[j]), 32'(j));
            end
        end

        // Address load to the top of memory, then wrap to zero
        do_reset();
        bus.mem_ack = 1'b1;
        load_en = 1'b1;
        load_addr = 10'h3FF;
        tick();
        load_en = 1'b0;
        send(vecs[0]);
        send(vecs[1]);
        repeat (5) tick();
        chk("wrap_count", 32'(wq.size()), 32'd2);
        if (wq.size() >= 2) begin
            chk("wrap_addr0", 32'(aq[0]), 32'h3FF);
            chk("wrap_data0", wq[0], vecs[0].exp);
            chk("wrap_addr1", 32'(aq[1]), 32'h000);
            chk("wrap_data1", wq[1], vecs[1].exp);
        end
        chk("wrap_pulses", 32'(wrap_cnt), 32'd1);

        // Illegal format is dropped and sets a sticky flag
        do_reset();
        bus.mem_ack = 1'b1;
        send(ill);
        @(negedge clk);
        chk("ill_err_set", 32'(err_fmt), 32'd1);
        chk("ill_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("ill_err_sticky", 32'(err_fmt), 32'd1);
        chk("ill_no_write", 32'(wq.size()), 32'd0);
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("ill_err_cleared", 32'(err_fmt), 32'd0);
        tick();
        set_tuple(ill);
        bus.in_valid = 1'b1;
        err_clr = 1'b1;
        @(negedge clk);
        chk("ill_clr_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        err_clr = 1'b0;
        @(negedge clk);
        chk("ill_clr_and_set", 32'(err_fmt), 32'd1);
        chk("ill_no_write2", 32'(wq.size()), 32'd0);

        // Reset with a pending write and two words queued
        do_reset();
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_tuple(vecs[i + 3]);
            bus.in_valid = 1'b1;
            tick();
        end
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rstp_we_before", 32'(bus.mem_we), 32'd1);
        chk("rstp_busy_before", 32'(busy), 32'd1);
        #2 rst_async = 1'b1;
        #1;
        chk("rstp_we_async", 32'(bus.mem_we), 32'd0);
        chk("rstp_busy_async", 32'(busy), 32'd0);
        chk("rstp_addr_async", 32'(bus.mem_addr), 32'd0);
        do_reset();
        bus.mem_ack = 1'b1;
        send(vecs[0]);
        repeat (6) tick();
        chk("rstp_count", 32'(wq.size()), 32'd1);
        if (wq.size() >= 1) begin
            chk("rstp_addr", 32'(aq[0]), 32'(BASE));
            chk("rstp_data", wq[0], vecs[0].exp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Packs individual instruction fields into 32-bit instruction words. Uses the same bit layout that the pipeline decoder unpacks. Streams the packed words into instruction memory at auto-incrementing addresses. Sits between the test/boot loader front end and the instruction memory write port, with a small FIFO to absorb memory stalls.

Parameters:
FIFO_DEPTH, 4, packed-word FIFO entries; power of two, at least 2
ADDR_W, 10, instruction memory word-address width
BASE_ADDR, 0, write address after reset; ADDR_W bits

Ports:
clk  input  1  clock
rst_async  input  1  reset, asynchronous, active-high
in_valid  input  1  field tuple valid
in_ready  output  1  encoder can accept a tuple
in_fmt  input  2  0=R, 1=I, 2=J, 3=illegal
in_op  input  4  opcode
in_rd  input  4  destination register
in_rs  input  4  source register
in_func  input  4  function code
in_rt  input  4  second source register (R only)
in_imm  input  16  immediate (I only)
in_offs  input  20  offset (J only)
load_en  input  1  load a new write address
load_addr  input  ADDR_W  address to load
mem_we  output  1  write request
mem_addr  output  ADDR_W  write word address
mem_wdata  output  32  packed instruction
mem_ack  input  1  memory accepts the write this cycle
busy  output  1  FIFO non-empty or mem_we high
wrapped  output  1  one-cycle pulse when the address wraps to 0
err_fmt  output  1  sticky illegal-format flag
err_clr  input  1  clears err_fmt

Behaviour:
- Reset state, entered asynchronously:
  - mem_we=0, mem_addr=0, mem_wdata=0, wrapped=0, err_fmt=0, busy=0.
  - FIFO is emptied; the internal address register is set to BASE_ADDR.
  - in_ready=1 once reset deasserts.
- Packing rule; all unlisted bits are 0:
  - Bits [31:28]=op and [27:24]=rd in every format.
  - R-type: [23:20]=rs, [19:16]=func, [3:0]=rt.
  - I-type: [23:20]=rs, [19:16]=func, [15:0]=imm.
  - J-type: [23:20]=rs, [19:0]=offs.
- Input handshake:
  - A tuple is accepted on a clk edge when in_valid && in_ready.
  - in_ready = !fifo_full. It is registered-state derived, with no combinational path from in_valid.
- Illegal format (in_fmt=3):
  - The tuple is accepted and dropped; it is not enqueued.
  - err_fmt is set on the following cycle.
- err_fmt:
  - Holds until err_clr=1 at a clk edge.
  - If err_clr and a new illegal accept occur in the same cycle, err_fmt stays 1.
- Output stage is a registered holding register, following valid/ack rules:
  - While mem_we && !mem_ack, mem_we, mem_addr and mem_wdata hold stable.
  - When mem_we==0, or mem_we && mem_ack, the register loads the FIFO head if the FIFO is non-empty. Otherwise mem_we drops to 0.
- Latency and throughput:
  - With an empty FIFO and idle output, a word accepted at edge N is presented with mem_we=1 after edge N+1.
  - With mem_ack held at 1, sustained throughput is one word per cycle.
- FIFO behaviour:
  - Push and pop in the same cycle are both performed, including when the FIFO is full.
  - When full, in_ready is 0 and the pop frees a slot for the next cycle.
- Address rules:
  - Each word loaded into the output register takes the current address register value.
  - The address register then increments modulo 2^ADDR_W.
  - Incrementing from 2^ADDR_W-1 to 0 pulses wrapped for exactly one cycle.
- load_en:
  - Overwrites the address register at that edge.
  - If a word is loaded into the output register in the same cycle, that word uses the pre-load address. The loaded value takes precedence over the increment.
  - A pending (unacked) write keeps its latched mem_addr.
- busy = fifo non-empty || mem_we.
- Reset during a pending write abandons it: mem_we falls asynchronously and the FIFO contents are lost.

Optional Feature:
ENC_TRACE_EN
- Defined: on every clk edge where mem_we && mem_ack, the block issues a $display line. The line reports "ENCODER", mem_addr, mem_wdata, and the decoded op/rd/rs fields.
- Also defined: each illegal-format accept prints a warning line.
- Undefined: no simulation output; all RTL behaviour is identical either way.

Test Plan:
- After reset, mem_ack=1, send R{op=3,rd=1,rs=2,func=4,rt=5} -> one cycle after accept: mem_we=1, mem_addr=0, mem_wdata=0x31240005; busy=0 after the ack.
- Send I{op=1,rd=2,rs=3,func=0,imm=0xBEEF} then J{op=0xA,rd=7,rs=0,offs=0xFFFFF} back-to-back, mem_ack=1 -> 0x1230BEEF at address 0, then 0xA70FFFFF at address 1, on consecutive cycles.
- Hold mem_ack=0, stream 6 tuples -> in_ready=0 after 5 accepts (4 in FIFO plus 1 held); mem_addr and mem_wdata stable. Release mem_ack -> all 6 words written in order to addresses 0-5.
- load_en with load_addr=0x3FF, then send 2 words -> written to 0x3FF then 0x000; wrapped pulses once.
- in_fmt=3 accepted -> no mem_we; err_fmt=1 and stays 1; err_clr=1 -> err_fmt=0.
- Assert rst_async while mem_we=1, mem_ack=0, with 2 words in the FIFO -> mem_we=0 immediately. Next word after reset goes to BASE_ADDR.
